// File: rtl/transmisor_serie_resultado_pkg.sv
// Shared definitions for the serial result transmitter: default width,
// FSM state codes and the parity helper.
package transmisor_serie_resultado_pkg;

  localparam int RES_WIDTH = 34;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_PAR  = 2'd2,
    ST_DONE = 2'd3
  } tx_state_t;

  // Callers zero-extend; padding zeros do not change even parity.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/transmisor_serie_resultado_if.sv
// Serial-side valid/ready link: the transmitter drives bit plus framing flags,
// the consumer answers with tx_ready.
interface transmisor_serie_resultado_if;
  logic tx_bit;
  logic tx_valid;
  logic tx_first;
  logic tx_last;
  logic tx_ready;

  modport master (output tx_bit, output tx_valid, output tx_first, output tx_last, input tx_ready);
  modport slave  (input tx_bit, input tx_valid, input tx_first, input tx_last, output tx_ready);
endinterface

// File: rtl/transmisor_serie_resultado_contador_tx.sv
// Beat counter for one frame: clears on capture, counts accepted data beats,
// flags the last data bit.
module contador_tx #(
  parameter int WIDTH = 34,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CE,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          terminal
);

  logic [CW-1:0] count_r;

  // Counter register: reset and clear win over increment; CE freezes it.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      count_r <= '0;
    end else if (CE) begin
      if (clear) begin
        count_r <= '0;
      end else if (inc) begin
        count_r <= count_r + CW'(1);
      end
    end
  end

  assign count    = count_r;
  assign terminal = (count_r == CW'(WIDTH - 1));

endmodule

// File: rtl/transmisor_serie_resultado.sv
// Bit-serial transmitter for the adder result word: capture on start, shift out
// one bit per accepted beat, optional trailing even-parity bit.
module transmisor_serie_resultado
  import transmisor_serie_resultado_pkg::*;
#(
  parameter int WIDTH     = RES_WIDTH,
  parameter int LSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          CE,
  input  logic                          start,
  input  logic [WIDTH-1:0]              DATA_IN,
  transmisor_serie_resultado_if.master  tx,
  output logic                          busy,
  output logic                          done
);

  localparam int CW = $clog2(WIDTH + 1);

  tx_state_t        state_r;
  tx_state_t        state_nx;
  logic [WIDTH-1:0] shreg_r;
  logic             parity_r;
  logic [CW-1:0]    count;
  logic             terminal;
  logic             capture_s;
  logic             data_accept_s;
  logic             bit_s;
  logic             valid_s;
  logic             first_s;
  logic             last_s;
  logic             busy_s;
  logic             done_s;

  assign capture_s     = (state_r == ST_IDLE) & start;
  assign data_accept_s = (state_r == ST_SEND) & tx.tx_ready;

  contador_tx #(.WIDTH(WIDTH), .CW(CW)) u_contador (
    .CLK      (CLK),
    .RESET    (RESET),
    .CE       (CE),
    .clear    (capture_s),
    .inc      (data_accept_s),
    .count    (count),
    .terminal (terminal)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r <= ST_IDLE;
    end else if (CE) begin
      state_r <= state_nx;
    end
  end

  // Data path: capture word and parity, then shift toward the output tap on each accept.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      shreg_r  <= '0;
      parity_r <= 1'b0;
    end else if (CE) begin
      if (capture_s) begin
        shreg_r  <= DATA_IN;
        parity_r <= even_parity(64'(DATA_IN));
      end else if (data_accept_s) begin
        if (LSB_FIRST != 0) begin
          shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
        end else begin
          shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nx = ST_SEND;
        else       state_nx = ST_IDLE;
      end
      ST_SEND: begin
        if (tx.tx_ready && terminal) state_nx = (PARITY_EN != 0) ? ST_PAR : ST_DONE;
        else                         state_nx = ST_SEND;
      end
      ST_PAR: begin
        if (tx.tx_ready) state_nx = ST_DONE;
        else             state_nx = ST_PAR;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output decode from state, counter and shift register only (no path from tx_ready).
  always_comb begin
    bit_s   = 1'b0;
    valid_s = 1'b0;
    first_s = 1'b0;
    last_s  = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_SEND: begin
        valid_s = 1'b1;
        busy_s  = 1'b1;
        bit_s   = (LSB_FIRST != 0) ? shreg_r[0] : shreg_r[WIDTH-1];
        first_s = (count == '0);
        last_s  = terminal & (PARITY_EN == 0);
      end
      ST_PAR: begin
        valid_s = 1'b1;
        busy_s  = 1'b1;
        bit_s   = parity_r;
        last_s  = 1'b1;
      end
      ST_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  assign tx.tx_bit   = bit_s;
  assign tx.tx_valid = valid_s;
  assign tx.tx_first = first_s;
  assign tx.tx_last  = last_s;
  assign busy        = busy_s;
  assign done        = done_s;

endmodule

// File: tb/tb_transmisor_serie_resultado.sv
// Three transmitter configurations (LSB/no parity, LSB/parity, MSB/no parity)
// share one stimulus stream; each is compared every cycle to a beat-index model.
module tb_transmisor_serie_resultado;

  localparam int W = 34;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ce;
  logic         start;
  logic         ready;
  logic [W-1:0] din;

  logic [2:0] o_bit, o_valid, o_first, o_last, o_busy, o_done;

  transmisor_serie_resultado_if sif0 ();
  transmisor_serie_resultado_if sif1 ();
  transmisor_serie_resultado_if sif2 ();

  assign sif0.tx_ready = ready;
  assign sif1.tx_ready = ready;
  assign sif2.tx_ready = ready;

  transmisor_serie_resultado #(.WIDTH(W), .LSB_FIRST(1), .PARITY_EN(0)) dut0 (
    .CLK(clk), .RESET(rst_n), .CE(ce), .start(start), .DATA_IN(din),
    .tx(sif0), .busy(o_busy[0]), .done(o_done[0]));
  transmisor_serie_resultado #(.WIDTH(W), .LSB_FIRST(1), .PARITY_EN(1)) dut1 (
    .CLK(clk), .RESET(rst_n), .CE(ce), .start(start), .DATA_IN(din),
    .tx(sif1), .busy(o_busy[1]), .done(o_done[1]));
  transmisor_serie_resultado #(.WIDTH(W), .LSB_FIRST(0), .PARITY_EN(0)) dut2 (
    .CLK(clk), .RESET(rst_n), .CE(ce), .start(start), .DATA_IN(din),
    .tx(sif2), .busy(o_busy[2]), .done(o_done[2]));

  assign o_bit   = {sif2.tx_bit,   sif1.tx_bit,   sif0.tx_bit};
  assign o_valid = {sif2.tx_valid, sif1.tx_valid, sif0.tx_valid};
  assign o_first = {sif2.tx_first, sif1.tx_first, sif0.tx_first};
  assign o_last  = {sif2.tx_last,  sif1.tx_last,  sif0.tx_last};

  always #5 clk = ~clk;

  // Reference model: b = -1 idle, 0..nb-1 beat on the line, nb = done cycle.
  bit           lsb_cfg [3] = '{1'b1, 1'b1, 1'b0};
  bit           par_cfg [3] = '{1'b0, 1'b1, 1'b0};
  int           b [3];
  logic [W-1:0] cap [3];
  int           k_edge [3];
  int           done_edge [3];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;

  function automatic int nb(input int i);
    return W + (par_cfg[i] ? 1 : 0);
  endfunction

  function automatic logic frame_bit(input logic [W-1:0] d, input int idx, input bit lsb);
    if (idx == W) return ^d;
    return lsb ? d[idx] : d[W-1-idx];
  endfunction

  task automatic check(input string tag, input int i, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s dut%0d cyc%0d: observed %0b expected %0b", tag, i, cyc, obs, exp);
  endtask

  task automatic check_int(input string tag, input int i, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s dut%0d: observed %0d expected %0d", tag, i, obs, exp);
  endtask

  task automatic step();
    logic ev, eb;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) b[i] = -1;
      else if (ce) begin
        if (b[i] < 0) begin
          if (start) begin b[i] = 0; cap[i] = din; k_edge[i] = cyc; end
        end else if (b[i] < nb(i)) begin
          if (ready) b[i]++;
        end else b[i] = -1;
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ev = (b[i] >= 0) && (b[i] < nb(i));
      eb = ev ? frame_bit(cap[i], b[i], lsb_cfg[i]) : 1'b0;
      check("tx_valid", i, o_valid[i], ev);
      check("tx_bit",   i, o_bit[i],   eb);
      check("tx_first", i, o_first[i], b[i] == 0);
      check("tx_last",  i, o_last[i],  b[i] == nb(i) - 1);
      check("busy",     i, o_busy[i],  ev);
      check("done",     i, o_done[i],  b[i] == nb(i));
      if (o_done[i] === 1'b1) done_edge[i] = cyc + 1;
    end
  endtask

  // One frame with an optional stall (ready low or CE low) starting at beat stall_at.
  task automatic run_frame(input logic [W-1:0] d, input int stall_at, input int stall_len, input bit use_ce);
    bit stalled = 1'b0;
    for (int i = 0; i < 3; i++) done_edge[i] = -1;
    din = d; start = 1'b1;
    step();
    start = 1'b0;
    din = {2'($urandom_range(3, 0)), 32'($urandom)};
    for (int t = 0; t < 80 && done_edge[1] < 0; t++) begin
      if (!stalled && stall_len > 0 && b[0] == stall_at) begin
        if (use_ce) ce = 1'b0; else ready = 1'b0;
        repeat (stall_len) step();
        ce = 1'b1; ready = 1'b1; stalled = 1'b1;
      end else step();
    end
    for (int i = 0; i < 3; i++)
      check_int("latency", i, done_edge[i] - k_edge[i], W + 1 + (par_cfg[i] ? 1 : 0) + stall_len);
    step(); step();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin b[i] = -1; cap[i] = '0; k_edge[i] = 0; done_edge[i] = -1; end
    rst_n = 1'b0; ce = 1'b1; start = 1'b0; ready = 1'b1; din = '0;
    step(); step();
    rst_n = 1'b1;
    step();

    run_frame(34'h2_0000_0001, -1, 0, 1'b0);
    run_frame(34'h2_0000_0001, 3, 5, 1'b0);
    run_frame(34'h1_5A5A_C3C3, 10, 3, 1'b1);
    run_frame(34'h0_0000_0007, -1, 0, 1'b0);

    // MSB-first frame with a start pulse mid-frame, then start held across DONE
    for (int i = 0; i < 3; i++) done_edge[i] = -1;
    din = 34'h2_0000_0000; start = 1'b1;
    step();
    start = 1'b0; din = 34'h3_FFFF_FFFF;
    for (int t = 0; t < 20 && b[2] != 5; t++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 60 && b[2] != nb(2); t++) step();
    start = 1'b1;
    step(); step();
    check_int("b2b_gap", 2, k_edge[2] - done_edge[2], 1);
    start = 1'b0;
    repeat (8) step();

    // reset mid-frame aborts without a done pulse
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    repeat (4) step();

    // random traffic
    for (int t = 0; t < 700; t++) begin
      din   = {2'($urandom_range(3, 0)), 32'($urandom)};
      start = ($urandom_range(9, 0) < 3);
      ready = ($urandom_range(9, 0) < 7);
      ce    = ($urandom_range(9, 0) < 9);
      rst_n = ($urandom_range(199, 0) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
